// File: rtl/bfu_pkg.sv
// Shared constants and helpers for the radix-2 butterfly.
// BFU_SAT_EN selects clamping instead of wrap on the outputs.
package bfu_pkg;

  localparam logic [1:0] TW_ONE     = 2'b00;
  localparam logic [1:0] TW_NEG_J   = 2'b01;
  localparam logic [1:0] TW_NEG_ONE = 2'b10;
  localparam logic [1:0] TW_POS_J   = 2'b11;

  // Widest component the clamp helper supports.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] sat_clip(
    input logic signed [MAX_W+1:0] v,
    input int                      w
  );
    logic signed [MAX_W+1:0] hi;
    logic signed [MAX_W+1:0] lo;
    hi        = '0;
    hi[w-1]   = 1'b1;
    hi        = hi - 1;
    lo        = -hi - 1;
    if (v > hi)      sat_clip = hi[MAX_W-1:0];
    else if (v < lo) sat_clip = lo[MAX_W-1:0];
    else             sat_clip = v[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/bfu_radix2_twiddle_rot.sv
// Multiplier-free rotation of B by W4^k.
// One extra bit keeps the negated most-negative value exact.
module bfu_twiddle_rot
  import bfu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic        [DATA_W-1:0] B_real,
  input  logic        [DATA_W-1:0] B_imag,
  input  logic        [1:0]        sel_w,
  output logic signed [DATA_W:0]   T_real,
  output logic signed [DATA_W:0]   T_imag
);

  logic signed [DATA_W:0] br;
  logic signed [DATA_W:0] bi;

  assign br = {B_real[DATA_W-1], B_real};
  assign bi = {B_imag[DATA_W-1], B_imag};

  always_comb begin
    T_real = br;
    T_imag = bi;
    unique case (1'b1)
      (sel_w == TW_ONE): begin
        T_real = br;
        T_imag = bi;
      end
      (sel_w == TW_NEG_J): begin
        T_real = bi;
        T_imag = -br;
      end
      (sel_w == TW_NEG_ONE): begin
        T_real = -br;
        T_imag = -bi;
      end
      (sel_w == TW_POS_J): begin
        T_real = -bi;
        T_imag = br;
      end
    endcase
  end

endmodule

// File: rtl/bfu_radix2.sv
// Radix-2 DIT butterfly: X0 = A + W*B, X1 = A - W*B, 1-cycle latency.
// Define BFU_SAT_EN to clamp outputs instead of wrapping.
module bfu_radix2
  import bfu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] A_real,
  input  logic [DATA_W-1:0] A_imag,
  input  logic [DATA_W-1:0] B_real,
  input  logic [DATA_W-1:0] B_imag,
  input  logic [1:0]        sel_w,
  output logic              out_valid,
  output logic [DATA_W-1:0] X0_real,
  output logic [DATA_W-1:0] X0_imag,
  output logic [DATA_W-1:0] X1_real,
  output logic [DATA_W-1:0] X1_imag,
  output logic              ovf
);

  localparam int WW = DATA_W + 2;

  logic signed [DATA_W:0] t_re;
  logic signed [DATA_W:0] t_im;
  logic signed [WW-1:0]   a_re_w;
  logic signed [WW-1:0]   a_im_w;
  logic signed [WW-1:0]   t_re_w;
  logic signed [WW-1:0]   t_im_w;
  logic signed [WW-1:0]   res [4];
  logic [DATA_W-1:0]      x_d [4];
  logic [DATA_W-1:0]      x_q [4];
  logic [3:0]             oor;
  logic                   vld_q;
  logic                   ovf_q;
  logic                   ovf_d;

  bfu_twiddle_rot #(.DATA_W(DATA_W)) u_rot (
    .B_real (B_real),
    .B_imag (B_imag),
    .sel_w  (sel_w),
    .T_real (t_re),
    .T_imag (t_im)
  );

  assign a_re_w = {{2{A_real[DATA_W-1]}}, A_real};
  assign a_im_w = {{2{A_imag[DATA_W-1]}}, A_imag};
  assign t_re_w = {t_re[DATA_W], t_re};
  assign t_im_w = {t_im[DATA_W], t_im};

  assign res[0] = a_re_w + t_re_w;
  assign res[1] = a_im_w + t_im_w;
  assign res[2] = a_re_w - t_re_w;
  assign res[3] = a_im_w - t_im_w;

  for (genvar i = 0; i < 4; i++) begin : g_comp
    // In range iff the top three bits all agree.
    assign oor[i] = ~(&res[i][WW-1:DATA_W-1]) &
                    (|res[i][WW-1:DATA_W-1]);
`ifdef BFU_SAT_EN
    logic [MAX_W-1:0] clip;
    assign clip = sat_clip(
      {{(MAX_W-DATA_W){res[i][WW-1]}}, res[i]}, DATA_W);
    assign x_d[i] = clip[DATA_W-1:0];
`else
    assign x_d[i] = res[i][DATA_W-1:0];
`endif
  end

  assign ovf_d = ovf_q | (in_valid & (|oor));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
    end else begin
      vld_q <= in_valid;
      ovf_q <= ovf_d;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) x_q[i] <= x_d[i];
      end
    end
  end

  assign out_valid = vld_q;
  assign ovf       = ovf_q;
  assign X0_real   = x_q[0];
  assign X0_imag   = x_q[1];
  assign X1_real   = x_q[2];
  assign X1_imag   = x_q[3];

endmodule

// File: tb/tb_bfu_radix2.sv
// Directed bench for bfu_radix2 with a scoreboard of expected results.
// Honours BFU_SAT_EN in its reference model.
module tb_bfu_radix2;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] x0r;
    logic [DW-1:0] x0i;
    logic [DW-1:0] x1r;
    logic [DW-1:0] x1i;
    logic          ov;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] A_real, A_imag, B_real, B_imag;
  logic [1:0]    sel_w;
  logic          out_valid;
  logic [DW-1:0] X0_real, X0_imag, X1_real, X1_imag;
  logic          ovf;

  int   n_vec = 0;
  int   n_bad = 0;
  res_t sb [$];
  res_t last;
  logic exp_ovf;

  always #5 clk = ~clk;

  bfu_radix2 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A_real    (A_real),
    .A_imag    (A_imag),
    .B_real    (B_real),
    .B_imag    (B_imag),
    .sel_w     (sel_w),
    .out_valid (out_valid),
    .X0_real   (X0_real),
    .X0_imag   (X0_imag),
    .X1_real   (X1_real),
    .X1_imag   (X1_imag),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] fit(input longint v, inout logic ov);
    longint hi = (longint'(1) << (DW - 1)) - 1;
    longint lo = -(longint'(1) << (DW - 1));
    if (v > hi || v < lo) ov = 1'b1;
`ifdef BFU_SAT_EN
    if (v > hi) return hi[DW-1:0];
    if (v < lo) return lo[DW-1:0];
`endif
    return v[DW-1:0];
  endfunction

  function automatic res_t model(input longint ar, ai, br, bi,
                                 input logic [1:0] s);
    res_t   r;
    longint tr, ti;
    logic   ov = 1'b0;
    case (s)
      2'b00:   begin tr = br;  ti = bi;  end
      2'b01:   begin tr = bi;  ti = -br; end
      2'b10:   begin tr = -br; ti = -bi; end
      default: begin tr = -bi; ti = br;  end
    endcase
    r.x0r = fit(ar + tr, ov);
    r.x0i = fit(ai + ti, ov);
    r.x1r = fit(ar - tr, ov);
    r.x1i = fit(ai - ti, ov);
    r.ov  = ov;
    return r;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".x0r"}, X0_real, last.x0r);
    chk({tag, ".x0i"}, X0_imag, last.x0i);
    chk({tag, ".x1r"}, X1_real, last.x1r);
    chk({tag, ".x1i"}, X1_imag, last.x1i);
    chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input string tag, input bit v,
                     input longint ar, ai, br, bi,
                     input logic [1:0] s);
    res_t r;
    in_valid = v;
    A_real = DW'(ar); A_imag = DW'(ai);
    B_real = DW'(br); B_imag = DW'(bi);
    sel_w  = s;
    if (v) sb.push_back(model(ar, ai, br, bi, s));
    @(posedge clk);
    #1;
    chk({tag, ".vld"}, {31'b0, out_valid}, {31'b0, v});
    if (out_valid && sb.size() > 0) begin
      r = sb.pop_front();
      last = r;
      exp_ovf = exp_ovf | r.ov;
    end
    check_outs(tag);
    @(negedge clk);
  endtask

  task automatic clear_model();
    sb.delete();
    last = '{default: '0};
    exp_ovf = 1'b0;
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0; in_valid = 1'b0; sel_w = 2'b00;
    A_real = '0; A_imag = '0; B_real = '0; B_imag = '0;
    repeat (2) @(negedge clk);
    chk("rst.vld", {31'b0, out_valid}, 32'd0);
    check_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    cyc("neg1", 1, -300, 0, 100, 0, 2'b10);
    cyc("one",  1, 200, 0, 300, 0, 2'b00);
    cyc("negj", 1, 10, 20, 3, 4, 2'b01);
    cyc("posj", 1, 10, 20, 3, 4, 2'b11);
    cyc("idle", 0, 0, 0, 0, 0, 2'b00);
    cyc("mix",  1, -7, 123456, -99, 65535, 2'b11);

    for (int i = 0; i < 4; i++)
      cyc("b2b", 1, $urandom_range(0, 1 << 20) - 500000,
          $urandom_range(0, 1 << 20) - 500000,
          $urandom_range(0, 1 << 20) - 500000,
          $urandom_range(0, 1 << 20) - 500000,
          2'($urandom_range(0, 3)));
    cyc("hold0", 0, 1, 2, 3, 4, 2'b01);
    cyc("hold1", 0, 5, 6, 7, 8, 2'b10);

    cyc("ovfp", 1, 64'h7FFF_FFFF, 0, 1, 0, 2'b00);
    cyc("ovfh", 0, 0, 0, 0, 0, 2'b00);
    cyc("minb", 1, 0, 0, -64'sh8000_0000, 0, 2'b10);
    cyc("sticky", 1, 1, 1, 1, 1, 2'b00);

    cyc("pre", 1, 11, 22, 33, 44, 2'b01);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    chk("arst.vld", {31'b0, out_valid}, 32'd0);
    check_outs("arst");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc("rel0", 0, 0, 0, 0, 0, 2'b00);
    cyc("rel1", 1, 10, 20, 3, 4, 2'b01);
    cyc("rel2", 0, 0, 0, 0, 0, 2'b00);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
